// File: rtl/reset_sequencer.sv
// Ordered release of NUM_STAGE synchronous reset domains once the PLL lock is stable.
// Lock loss or a soft-reset request reasserts every stage and restarts the sequence.
module reset_sequencer #(
  parameter int    NUM_STAGE      = 4,
  parameter int    STAGE_GAP      = 16,
  parameter int    LOCK_FILTER    = 8,
  parameter int    HOLD_CYCLE     = 4,
  parameter string OUT_RST_ACTIVE = "HIGH"
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  input  logic                 i_pll_locked,
  input  logic                 i_sw_rst,
  output logic [NUM_STAGE-1:0] o_srst,
  output logic                 o_done,
  output logic [1:0]           o_state
);

  // state       | meaning
  // S_HOLD      | all stages asserted for at least HOLD_CYCLE cycles
  // S_LOCK_WAIT | waiting for LOCK_FILTER consecutive synchronized lock cycles
  // S_RELEASE   | releasing one stage every STAGE_GAP cycles
  // S_RUN       | all stages released
  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_LOCK_WAIT = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam int HCW = (HOLD_CYCLE  > 1) ? $clog2(HOLD_CYCLE)  : 1;
  localparam int LCW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int GCW = (STAGE_GAP   > 1) ? $clog2(STAGE_GAP)   : 1;
  localparam int IW  = (NUM_STAGE   > 1) ? $clog2(NUM_STAGE)   : 1;

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLE - 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_FILTER - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(STAGE_GAP - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_STAGE - 1);
  localparam bit             ACT_HIGH  = (OUT_RST_ACTIVE == "HIGH");

  logic                 r_sync1;
  logic                 r_sync2;
  state_t               r_state;
  logic [HCW-1:0]       r_hold_cnt;
  logic [LCW-1:0]       r_lock_cnt;
  logic [GCW-1:0]       r_gap_cnt;
  logic [IW-1:0]        r_idx;
  logic [NUM_STAGE-1:0] r_rel;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [HCW-1:0]       w_hold_nxt;
  logic [LCW-1:0]       w_lock_nxt;
  logic [GCW-1:0]       w_gap_nxt;
  logic [IW-1:0]        w_idx_nxt;
  logic [NUM_STAGE-1:0] w_rel_nxt;
  logic                 w_done_nxt;

  logic w_sync_lock;
  logic w_abort;
  logic w_hold_tc;
  logic w_lock_tc;
  logic w_gap_tc;
  logic w_last_stage;

  assign w_sync_lock  = r_sync2;
  assign w_hold_tc    = (r_hold_cnt == HOLD_LAST);
  assign w_lock_tc    = (r_lock_cnt == LOCK_LAST);
  assign w_gap_tc     = (r_gap_cnt == GAP_LAST);
  assign w_last_stage = (r_idx == IDX_LAST);
  // Lock loss only aborts once sequencing has started; LOCK_WAIT just refilters.
  assign w_abort = (r_state != S_HOLD) &&
                   (i_sw_rst || (!w_sync_lock && (r_state == S_RELEASE || r_state == S_RUN)));

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_state    <= S_HOLD;
      r_hold_cnt <= '0;
      r_lock_cnt <= '0;
      r_gap_cnt  <= '0;
      r_idx      <= '0;
      r_rel      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_sync1    <= i_pll_locked;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_idx      <= w_idx_nxt;
      r_rel      <= w_rel_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HOLD: begin
        if (!i_sw_rst && w_hold_tc) w_state_nxt = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (w_abort)                        w_state_nxt = S_HOLD;
        else if (w_sync_lock && w_lock_tc)  w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (w_abort)                        w_state_nxt = S_HOLD;
        else if (w_gap_tc && w_last_stage)  w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_abort) w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_HOLD;
    endcase
  end

  // Counters default to zero so every state exit leaves them cleared.
  always_comb begin
    w_hold_nxt = '0;
    w_lock_nxt = '0;
    w_gap_nxt  = '0;
    w_idx_nxt  = r_idx;
    w_rel_nxt  = r_rel;
    w_done_nxt = r_done;
    if (w_abort) begin
      w_idx_nxt  = '0;
      w_rel_nxt  = '0;
      w_done_nxt = 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          w_idx_nxt  = '0;
          w_rel_nxt  = '0;
          w_done_nxt = 1'b0;
          if (!i_sw_rst && !w_hold_tc) w_hold_nxt = r_hold_cnt + 1'b1;
        end
        S_LOCK_WAIT: begin
          w_idx_nxt = '0;
          if (w_sync_lock && !w_lock_tc) w_lock_nxt = r_lock_cnt + 1'b1;
        end
        S_RELEASE: begin
          if (w_gap_tc) begin
            w_rel_nxt[r_idx] = 1'b1;
            if (w_last_stage) begin
              w_idx_nxt  = '0;
              w_done_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_gap_nxt = r_gap_cnt + 1'b1;
          end
        end
        S_RUN: begin
          w_done_nxt = 1'b1;
        end
        default: begin
          w_rel_nxt  = '0;
          w_done_nxt = 1'b0;
        end
      endcase
    end
  end

  assign o_srst  = ACT_HIGH ? ~r_rel : r_rel;
  assign o_done  = r_done;
  assign o_state = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: timed expectations are queued per scenario and
// compared at the matching edge against a HIGH- and a LOW-polarity instance.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       arst;
  logic       pll_locked;
  logic       sw_rst;
  logic [3:0] srst_hi, srst_lo;
  logic       done_hi, done_lo;
  logic [1:0] state_hi, state_lo;

  typedef struct {
    int         edge_n;
    logic [3:0] srst;
    logic       done;
    logic [1:0] state;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   edge_n   = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.OUT_RST_ACTIVE("HIGH")) u_dut_hi (
    .i_clk(clk), .i_arst(arst), .i_pll_locked(pll_locked), .i_sw_rst(sw_rst),
    .o_srst(srst_hi), .o_done(done_hi), .o_state(state_hi));

  reset_sequencer #(.OUT_RST_ACTIVE("LOW")) u_dut_lo (
    .i_clk(clk), .i_arst(arst), .i_pll_locked(pll_locked), .i_sw_rst(sw_rst),
    .o_srst(srst_lo), .o_done(done_lo), .o_state(state_lo));

  task automatic push(input int e, input logic [3:0] s, input logic d,
                      input logic [1:0] st, input string tag);
    exp_t x;
    x.edge_n = e; x.srst = s; x.done = d; x.state = st; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic compare(input exp_t e);
    logic [3:0] lo_exp;
    lo_exp = ~e.srst;
    n_checks++;
    assert (srst_hi === e.srst) else begin
      n_err++;
      $error("FAIL %s srst_hi edge %0d: got %b exp %b", e.tag, edge_n, srst_hi, e.srst);
    end
    n_checks++;
    assert (srst_lo === lo_exp) else begin
      n_err++;
      $error("FAIL %s srst_lo edge %0d: got %b exp %b", e.tag, edge_n, srst_lo, lo_exp);
    end
    n_checks++;
    assert (done_hi === e.done && done_lo === e.done) else begin
      n_err++;
      $error("FAIL %s done edge %0d: got %b/%b exp %b", e.tag, edge_n, done_hi, done_lo, e.done);
    end
    n_checks++;
    assert (state_hi === e.state && state_lo === e.state) else begin
      n_err++;
      $error("FAIL %s state edge %0d: got %0d/%0d exp %0d", e.tag, edge_n, state_hi, state_lo, e.state);
    end
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    edge_n++;
    while (sb.size() > 0 && sb[0].edge_n <= edge_n) begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic do_reset();
    arst       = 1'b0;
    pll_locked = 1'b1;
    sw_rst     = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    push(0, 4'hF, 1'b0, 2'd0, "reset_state");
    check_now();
    arst   = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    arst       = 1'b1;
    pll_locked = 1'b1;
    sw_rst     = 1'b0;

    // Power-up, soft reset in RUN, then soft reset colliding with a stage release
    do_reset();
    push(3,   4'hF, 0, 2'd0, "pu_hold");
    push(4,   4'hF, 0, 2'd1, "pu_lockwait");
    push(11,  4'hF, 0, 2'd1, "pu_lockwait_end");
    push(12,  4'hF, 0, 2'd2, "pu_release");
    push(27,  4'hF, 0, 2'd2, "pu_pre_bit0");
    push(28,  4'hE, 0, 2'd2, "pu_bit0");
    push(43,  4'hE, 0, 2'd2, "pu_pre_bit1");
    push(44,  4'hC, 0, 2'd2, "pu_bit1");
    push(60,  4'h8, 0, 2'd2, "pu_bit2");
    push(75,  4'h8, 0, 2'd2, "pu_pre_bit3");
    push(76,  4'h0, 1, 2'd3, "pu_run");
    push(90,  4'h0, 1, 2'd3, "pu_run_hold");
    push(100, 4'h0, 1, 2'd3, "sw_pre");
    push(101, 4'hF, 0, 2'd0, "sw_hold");
    push(104, 4'hF, 0, 2'd0, "sw_hold_end");
    push(105, 4'hF, 0, 2'd1, "sw_lockwait");
    push(113, 4'hF, 0, 2'd2, "sw_release");
    push(128, 4'hF, 0, 2'd2, "sw_pre_bit0");
    push(129, 4'hE, 0, 2'd2, "sw_bit0");
    push(144, 4'hE, 0, 2'd2, "col_pre");
    push(145, 4'hF, 0, 2'd0, "col_abort");
    push(149, 4'hF, 0, 2'd1, "col_lockwait");
    run_to(100);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    run_to(144);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    run_to(150);

    // One-cycle lock glitch during LOCK_WAIT
    do_reset();
    push(7,  4'hF, 0, 2'd1, "gl_lockwait");
    push(12, 4'hF, 0, 2'd1, "gl_slipped");
    push(17, 4'hF, 0, 2'd1, "gl_lockwait_end");
    push(18, 4'hF, 0, 2'd2, "gl_release");
    push(33, 4'hF, 0, 2'd2, "gl_pre_bit0");
    push(34, 4'hE, 0, 2'd2, "gl_bit0");
    run_to(7);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    run_to(34);

    // Lock loss after stage 1 released, then recovery
    do_reset();
    push(44, 4'hC, 0, 2'd2, "ll_bit1");
    push(52, 4'hC, 0, 2'd2, "ll_sync_delay");
    push(53, 4'hF, 0, 2'd0, "ll_abort");
    push(57, 4'hF, 0, 2'd1, "ll_lockwait");
    push(60, 4'hF, 0, 2'd1, "ll_no_lock");
    push(69, 4'hF, 0, 2'd1, "ll_lockwait_end");
    push(70, 4'hF, 0, 2'd2, "ll_release");
    push(86, 4'hE, 0, 2'd2, "ll_bit0");
    run_to(50);
    pll_locked = 1'b0;
    run_to(60);
    pll_locked = 1'b1;
    run_to(86);

    // Asynchronous reset mid-RELEASE, checked before any further clock edge
    do_reset();
    push(50, 4'hC, 0, 2'd2, "ar_pre");
    run_to(50);
    #2;
    arst = 1'b0;
    #1;
    push(50, 4'hF, 0, 2'd0, "ar_async");
    check_now();
    arst = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Power-on and soft reset controller that releases NUM_STAGE synchronous reset domains in order, one per clock domain stage (e.g. PLL-fed logic, interconnect, cores, peripherals).
- Holds all stages in reset until the PLL lock is stable, then deasserts each stage STAGE_GAP cycles apart.
- On lock loss or a soft-reset request it reasserts everything and restarts the sequence.
- Sits after the per-domain reset synchronizers at the top of the design.

Parameters:
- NUM_STAGE, 4, number of sequenced reset outputs (>=1).
- STAGE_GAP, 16, cycles between successive stage releases (>=1).
- LOCK_FILTER, 8, consecutive cycles the synchronized lock must be high before sequencing starts (>=1).
- HOLD_CYCLE, 4, minimum cycles all stages stay asserted in HOLD (>=1).
- OUT_RST_ACTIVE, "HIGH", polarity of o_srst: "HIGH" or "LOW".

Ports:
- i_clk  input  1  single system clock; all logic is posedge.
- i_arst  input  1  asynchronous, active-low reset. Asserting it forces the reset state immediately.
- i_pll_locked  input  1  PLL lock, asynchronous to i_clk; passed through an internal 2-flop synchronizer that resets to 0.
- i_sw_rst  input  1  synchronous, active-high soft-reset request; one cycle is sufficient.
- o_srst  output  NUM_STAGE  per-stage synchronous reset. Bit k is released k-th. Polarity is set by OUT_RST_ACTIVE.
- o_done  output  1  high while all stages are released (RUN).
- o_state  output  2  debug encoding: HOLD=0, LOCK_WAIT=1, RELEASE=2, RUN=3.

Behaviour:
- Reset (i_arst=0), applied asynchronously:
  - state=HOLD; all o_srst bits asserted.
  - o_done=0; hold_cnt, lock_cnt, gap_cnt, stage idx all 0; synchronizer flops 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- HOLD:
  - All stages are asserted and hold_cnt increments.
  - When hold_cnt==HOLD_CYCLE-1, the next edge goes to LOCK_WAIT and hold_cnt clears.
  - i_sw_rst in HOLD restarts hold_cnt at 0.
- LOCK_WAIT:
  - lock_cnt increments on each cycle with sync_lock=1 and clears to 0 on any cycle with sync_lock=0.
  - When lock_cnt==LOCK_FILTER-1 and sync_lock=1, the next edge goes to RELEASE with gap_cnt=0 and idx=0.
- RELEASE:
  - gap_cnt increments each cycle.
  - When gap_cnt==STAGE_GAP-1, on that edge: o_srst[idx] deasserts, gap_cnt clears, idx increments.
  - Stage k therefore deasserts (k+1)*STAGE_GAP edges after entering RELEASE.
  - On the edge that releases stage NUM_STAGE-1, the state goes to RUN and o_done rises on the same edge.
  - Released stages stay released; unreleased stages stay asserted.
- RUN: all stages are released and o_done=1.
- Abort conditions:
  - In LOCK_WAIT, RELEASE or RUN, either sync_lock=0 (in RELEASE/RUN only) or i_sw_rst=1 causes the next edge to enter HOLD.
  - On that edge all o_srst bits reassert simultaneously, o_done=0, and all counters clear.
  - Lock loss and soft reset have identical effect.
  - An abort takes priority over a stage release scheduled on the same edge.
- Counter widths: clog2 of the respective parameter, with a minimum of 1 bit. Counters never wrap because they are compared and cleared at terminal count.
- Output polarity: o_srst asserted equals 1 if OUT_RST_ACTIVE=="HIGH", else 0. o_done and o_state are unaffected by polarity.
- Mid-sequence i_arst assertion: immediate asynchronous return to the reset state from any state.

Test Plan (defaults, edges counted from the first posedge with i_arst=1, i_pll_locked=1 throughout):
- Power-up sequence:
  - o_state=1 from edge 4 and 2 from edge 12.
  - o_srst releases bit 0 at edge 28, bit 1 at 44, bit 2 at 60, bit 3 at 76.
  - o_done=1 and o_state=3 at edge 76; o_srst=4'b0000 after.
- Lock glitch in LOCK_WAIT:
  - Drop i_pll_locked for 1 cycle around edge 8; lock_cnt clears.
  - RELEASE entry slips accordingly; o_srst stays 4'b1111 until 8 clean synchronized cycles are seen.
- Lock loss in RELEASE:
  - Drop i_pll_locked after bit 1 is released (edge ~50).
  - Within 3 edges (2 synchronizer + 1) o_srst=4'b1111 and o_state=0.
  - Full sequence repeats once lock returns.
- Soft reset in RUN:
  - 1-cycle i_sw_rst at edge 100 → edge 101 o_srst=4'b1111, o_done=0.
  - Stage 0 re-releases at edge 101+4+8+16=129.
- Collision: i_sw_rst asserted on the exact edge a stage would release → that stage stays asserted; state goes to HOLD.
- Async reset and polarity:
  - Assert i_arst=0 mid-RELEASE → outputs return to reset values without a clock edge.
  - Repeat with OUT_RST_ACTIVE="LOW": o_srst reset value is 4'b0000 and release order is unchanged.
